// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and writes them to consecutive instruction memory addresses.
// Latency: one word per 2 cycles (accept edge, then a one-cycle write); ready_o drops while writing, when full, or in DONE/ERROR.
module instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        kind_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        shamt_i,
   input  logic [5:0]        funct_i,
   input  logic [15:0]       imm_i,
   input  logic [25:0]       target_i,
   input  logic              last_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   output logic [ADDR_W-1:0] instr_count_o,
   output logic              full_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_SLTI = 6'd10;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;
   localparam logic [5:0] OP_J    = 6'd2;
   localparam logic [5:0] OP_JAL  = 6'd3;

   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;

   state_t            state, stateNext;
   logic [ADDR_W-1:0] count, countNext;
   logic [31:0]       dataReg, encWord;
   logic              lastReg, acceptWord;

   always_comb begin
      encWord = 32'd0;
      case (kind_i)
         3'd0: encWord = {OP_R, rs_i, rt_i, rd_i, shamt_i, funct_i};
         3'd1: encWord = {OP_ADDI, rs_i, rt_i, imm_i};
         3'd2: encWord = {OP_SLTI, rs_i, rt_i, imm_i};
         3'd3: encWord = {OP_BEQ, rs_i, rt_i, imm_i};
         3'd4: encWord = {OP_LW, rs_i, rt_i, imm_i};
         3'd5: encWord = {OP_SW, rs_i, rt_i, imm_i};
         3'd6: encWord = {OP_J, target_i};
         3'd7: encWord = {OP_JAL, target_i};
         default: encWord = 32'd0;
      endcase
   end

   always_comb begin
      stateNext  = state;
      countNext  = count;
      acceptWord = 1'b0;
      case (state)
         IDLE: begin
            if (valid_i && !full_o) begin
               acceptWord = 1'b1;
               stateNext  = WRITE;
            end else if (valid_i) begin
               // A word offered with the buffer already full and no prior last_i is an overflow.
               stateNext = ERROR;
            end
         end
         WRITE: begin
            countNext = count + 1'b1;
            stateNext = lastReg ? DONE : IDLE;
         end
         DONE, ERROR: begin
            if (start_i) begin
               countNext = '0;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         count   <= '0;
         dataReg <= 32'd0;
         lastReg <= 1'b0;
      end else begin
         state <= stateNext;
         count <= countNext;
         if (acceptWord) begin
            dataReg <= encWord;
            lastReg <= last_i;
         end
      end
   end

   assign full_o        = (count == LIMIT);
   assign ready_o       = (state == IDLE) && !full_o;
   assign mem_we_o      = (state == WRITE);
   assign mem_addr_o    = BASE + (count << 2);
   assign mem_data_o    = dataReg;
   assign instr_count_o = count;
   assign done_o        = (state == DONE);
   assign err_o         = (state == ERROR);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected writes are queued at accept time and matched by a write monitor.
module tb_instr_encoder;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              clk_i = 1'b0;
   logic              rst_i, start_i, valid_i, last_i;
   logic [2:0]        kind_i;
   logic [4:0]        rs_i, rt_i, rd_i, shamt_i;
   logic [5:0]        funct_i;
   logic [15:0]       imm_i;
   logic [25:0]       target_i;
   logic              ready_o, mem_we_o, full_o, done_o, err_o;
   logic [ADDR_W-1:0] mem_addr_o, instr_count_o;
   logic [31:0]       mem_data_o;

   int checks   = 0;
   int failures = 0;
   int expCount = 0;
   logic [ADDR_W+31:0] expQ[$];

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
      .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
      .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i), .last_i(last_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .instr_count_o(instr_count_o), .full_o(full_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (mem_we_o) begin
         chk("write_expected", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) begin
            logic [ADDR_W+31:0] e;
            e = expQ.pop_front();
            chk("write_addr", 32'(mem_addr_o), 32'(e[ADDR_W+31:32]));
            chk("write_data", mem_data_o, e[31:0]);
         end
      end
   end

   task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] im, input logic [25:0] tg, input logic lst,
                       input logic [31:0] expData);
      int n;
      n = 0;
      kind_i = k; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh;
      funct_i = fn; imm_i = im; target_i = tg; last_i = lst; valid_i = 1'b1;
      while (!ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("accept_ready", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      expQ.push_back({ADDR_W'(expCount * 4), expData});
      expCount++;
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      expCount = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      expCount = 0;
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
      kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0;
      funct_i = '0; imm_i = '0; target_i = '0;
      @(negedge clk_i);
      do_reset();

      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_we", 32'(mem_we_o), 32'd0);
      chk("rst_addr", 32'(mem_addr_o), 32'd0);
      chk("rst_data", mem_data_o, 32'd0);
      chk("rst_count", 32'(instr_count_o), 32'd0);
      chk("rst_flags", {29'd0, full_o, done_o, err_o}, 32'd0);

      // Single ADDI: ready low during WRITE, high again 2 cycles after accept.
      send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 32'h20080005);
      chk("addi_ready_write", 32'(ready_o), 32'd0);
      chk("addi_we_write", 32'(mem_we_o), 32'd1);
      @(negedge clk_i);
      chk("addi_ready_back", 32'(ready_o), 32'd1);
      chk("addi_count", 32'(instr_count_o), 32'd1);
      chk("addi_we_low", 32'(mem_we_o), 32'd0);

      // start_i in IDLE is ignored.
      start_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      chk("idle_start_count", 32'(instr_count_o), 32'd1);
      chk("idle_start_ready", 32'(ready_o), 32'd1);
      chk("idle_start_done", 32'(done_o), 32'd0);

      // Back-to-back stream ending in DONE.
      do_reset();
      send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'd0, 1'b0, 32'h00221820);
      send(3'd4, 5'd5, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0, 32'h8CA40008);
      send(3'd5, 5'd3, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1, 32'hAC620004);
      @(negedge clk_i);
      chk("stream_done", 32'(done_o), 32'd1);
      chk("stream_ready", 32'(ready_o), 32'd0);
      chk("stream_count", 32'(instr_count_o), 32'd3);
      pulse_start();
      chk("done_start_count", 32'(instr_count_o), 32'd0);
      chk("done_start_done", 32'(done_o), 32'd0);
      chk("done_start_ready", 32'(ready_o), 32'd1);

      // BEQ with all-ones offset, then JAL last.
      send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 32'h1022FFFF);
      send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10, 1'b1, 32'h0C000010);
      @(negedge clk_i);
      chk("jal_done", 32'(done_o), 32'd1);
      pulse_start();

      // Fill to DEPTH with no last_i, unused fields driven with junk, then overflow.
      send(3'd2, 5'd2, 5'd3, 5'd9, 5'd7, 6'h3F, 16'h1234, 26'h155, 1'b0, 32'h28431234);
      send(3'd6, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0BFFFFFF);
      send(3'd0, 5'd0, 5'd0, 5'd1, 5'd2, 6'd0, 16'hABCD, 26'h2AAAAAA, 1'b0, 32'h00000880);
      send(3'd1, 5'd7, 5'd7, 5'd15, 5'd3, 6'h2A, 16'hFFFF, 26'h1, 1'b0, 32'h20E7FFFF);
      @(negedge clk_i);
      chk("fill_full", 32'(full_o), 32'd1);
      chk("fill_ready", 32'(ready_o), 32'd0);
      chk("fill_err_before", 32'(err_o), 32'd0);
      valid_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      chk("ovf_err", 32'(err_o), 32'd1);
      chk("ovf_ready", 32'(ready_o), 32'd0);
      chk("ovf_count", 32'(instr_count_o), 32'd4);
      pulse_start();
      chk("err_start_count", 32'(instr_count_o), 32'd0);
      chk("err_start_err", 32'(err_o), 32'd0);
      chk("err_start_ready", 32'(ready_o), 32'd1);

      // DEPTH-th word carrying last_i finishes cleanly.
      for (int i = 0; i < DEPTH; i++)
         send(3'd1, 5'(i), 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'(i == DEPTH - 1),
              {6'd8, 5'(i), 5'd1, 16'(i)});
      @(negedge clk_i);
      chk("lastfull_done", 32'(done_o), 32'd1);
      chk("lastfull_err", 32'(err_o), 32'd0);
      chk("lastfull_full", 32'(full_o), 32'd1);
      pulse_start();

      // Reset in the middle of WRITE drops the word from the count.
      send(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'h8C210010);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      expCount = 0;
      chk("rstw_we", 32'(mem_we_o), 32'd0);
      chk("rstw_count", 32'(instr_count_o), 32'd0);
      chk("rstw_ready", 32'(ready_o), 32'd1);
      send(3'd5, 5'd4, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0020, 26'd0, 1'b0, 32'hAC860020);
      @(negedge clk_i);
      chk("rstw_next_count", 32'(instr_count_o), 32'd1);

      repeat (3) @(negedge clk_i);
      chk("queue_drained", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential MIPS instruction encoder: the writer side of the opcode/field format consumed by the main control decoder.
- Accepts symbolic instructions through a valid/ready handshake and packs them into 32-bit MIPS words.
- Writes each word into instruction memory at consecutive PC-aligned byte addresses.
- Used by the bench and by the boot loader to build programs for the single-cycle CPU.

Parameters:
ADDR_W, 10, byte-address width of mem_addr_o and instr_count_o
DEPTH, 256, maximum words written per program; DEPTH*4 <= 2^ADDR_W
BASE_ADDR, 0, byte address of the first word; multiple of 4

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  from DONE/ERROR: clear pointer and count, return to IDLE
valid_i  in  1  instruction fields valid
ready_o  out  1  encoder can accept this cycle
kind_i  in  3  0=R,1=ADDI,2=SLTI,3=BEQ,4=LW,5=SW,6=J,7=JAL
rs_i / rt_i / rd_i / shamt_i  in  5 each  register and shift fields
funct_i  in  6  R-type function field
imm_i  in  16  immediate/offset, raw bits, no extension
target_i  in  26  J/JAL word target
last_i  in  1  marks final instruction of program
mem_we_o  out  1  instruction memory write strobe
mem_addr_o  out  ADDR_W  byte address of write
mem_data_o  out  32  encoded instruction word
instr_count_o  out  ADDR_W  words written since reset/start
full_o  out  1  instr_count_o == DEPTH
done_o  out  1  program complete
err_o  out  1  sticky error; illegal kind_i is impossible with 3-bit encoding, so err_o flags only a last_i-less overflow attempt

Behaviour:
- Reset values: state=IDLE, ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, instr_count_o=0, full_o=0, done_o=0, err_o=0.
- Opcodes: R=0, ADDI=8, SLTI=10, BEQ=4, LW=35, SW=43, J=2, JAL=3.
- R-type word = {6'd0, rs, rt, rd, shamt, funct}.
- I-type word (ADDI/SLTI/BEQ/LW/SW) = {op, rs, rt, imm}.
- J/JAL word = {op, target}.
- Unused input fields are ignored.
- States: IDLE, WRITE, DONE, ERROR.
- IDLE:
  - ready_o = ~full_o.
  - On valid_i & ready_o (edge N), register the encoded word into mem_data_o, register last_i, go to WRITE.
  - If valid_i is high while full_o is set, go to ERROR and set err_o. No word is accepted.
- WRITE (cycle N+1):
  - mem_we_o=1, ready_o=0, mem_addr_o = BASE_ADDR + 4*instr_count_o.
  - At the end of the cycle: instr_count_o += 1, then DONE if the registered last flag is set, else IDLE.
- Timing: one instruction per 2 cycles. mem_we_o is a single-cycle pulse per accepted instruction and is never high outside WRITE. mem_data_o and mem_addr_o are stable throughout WRITE.
- DONE: done_o=1, ready_o=0. start_i returns to IDLE with instr_count_o=0 and done_o cleared.
- ERROR: err_o=1, ready_o=0. start_i clears err_o and the count and returns to IDLE.
- start_i in IDLE or WRITE is ignored.
- Boundary conditions:
  - Accepting the DEPTH-th word sets full_o after its WRITE. If that word carried last_i, go to DONE with no error.
  - Address arithmetic wraps modulo 2^ADDR_W. This cannot occur given the DEPTH constraint.
  - rst_i during WRITE: mem_we_o is 0 from the next edge. The word in flight is not counted.
  - rst_i has priority over start_i and valid_i.

Test Plan:
- Reset, then ADDI rs=0 rt=8 imm=5 -> one mem_we_o pulse, addr 0x000, data 0x20080005, instr_count_o=1, ready_o back high 2 cycles after accept.
- Back-to-back stream: R rs=1 rt=2 rd=3 funct=0x20; LW rs=5 rt=4 imm=8; SW rs=3 rt=2 imm=4 (last) -> data 0x00221820@0x000, 0x8CA40008@0x004, 0xAC620004@0x008; done_o=1; ready_o=0.
- BEQ rs=1 rt=2 imm=0xFFFF, then JAL target=0x10 with last_i -> 0x1022FFFF@0x000, 0x0C000010@0x004, done_o=1.
- DEPTH=4: write 4 words without last_i, hold valid_i -> full_o=1, ERROR, err_o=1, no 5th write. start_i -> count 0, err_o 0, ready_o 1.
- Assert rst_i during WRITE -> mem_we_o low next cycle, instr_count_o=0, state IDLE. Next accepted word goes to 0x000.
- valid_i held low while start_i pulses in IDLE -> no state change, no writes.
